// File: rtl/conv_sched.sv
// conv_sched: convolution layer scheduler. Accepts a layer descriptor, splits
// the output channels into groups of 32, and for each group requests the
// group's weights, waits for them to land in the MAC array, starts one MAC
// pass and waits for it to finish. Pulses layer_done when all groups are done.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   desc_vld/desc_rdy           descriptor handshake
//   desc_in_ch/out_ch/map_size  layer shape; desc_wbase weight base address
//   wload_req/ack/addr/len      weight-load request (held until ack)
//   wload_done                  group weights written into the MAC array
//   conv_start/conv_done        MAC pass start pulse / completion pulse
//   in_ch/out_ch/map_size       latched layer configuration
//   grp_idx                     current output-channel group
//   layer_done, busy            layer completion pulse, not-idle flag
//   perf_cycles                 busy-cycle counter (only with CONV_SCHED_PERF_EN)
//
// Optional feature macro: CONV_SCHED_PERF_EN.
module conv_sched (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        desc_vld,
  output logic        desc_rdy,
  input  logic [7:0]  desc_in_ch,
  input  logic [7:0]  desc_out_ch,
  input  logic [15:0] desc_map_size,
  input  logic [31:0] desc_wbase,
  output logic        wload_req,
  input  logic        wload_ack,
  output logic [31:0] wload_addr,
  output logic [15:0] wload_len,
  input  logic        wload_done,
  output logic        conv_start,
  input  logic        conv_done,
  output logic [7:0]  in_ch,
  output logic [7:0]  out_ch,
  output logic [15:0] map_size,
  output logic [2:0]  grp_idx,
  output logic        layer_done,
  output logic        busy
`ifdef CONV_SCHED_PERF_EN
  ,
  output logic [31:0] perf_cycles
`endif
);

  localparam int unsigned NGRP_W = 4;
  localparam int unsigned SUM_W  = 9;
  localparam logic [15:0] WORDS_PER_CH = 16'd80;

  typedef enum logic [2:0] {IDLE, WREQ, WWAIT, START, CWAIT, NEXT} state_t;

  state_t state, state_n;

  logic              accept_c;
  logic              empty_c;
  logic              last_c;
  logic [SUM_W-1:0]  ngrp_sum_c;
  logic [NGRP_W-1:0] ngrp_c;

  // Group count is ceil(out_ch/32), 1..8 for a non-empty layer.
  assign ngrp_sum_c = SUM_W'(out_ch) + SUM_W'(31);
  assign ngrp_c     = NGRP_W'(ngrp_sum_c >> 5);
  assign last_c     = (NGRP_W'(grp_idx) + NGRP_W'(1)) >= ngrp_c;
  assign accept_c   = (state == IDLE) && desc_vld;
  assign empty_c    = (desc_in_ch == 8'd0) || (desc_out_ch == 8'd0);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  // Next-state logic; an empty layer is completed without leaving IDLE.
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (accept_c && !empty_c) state_n = WREQ;
      WREQ:    if (wload_ack)  state_n = WWAIT;
      WWAIT:   if (wload_done) state_n = START;
      START:   state_n = CWAIT;
      CWAIT:   if (conv_done)  state_n = NEXT;
      NEXT:    state_n = last_c ? IDLE : WREQ;
      default: state_n = IDLE;
    endcase
  end

  // Registered handshake/status outputs track the state being entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      desc_rdy   <= 1'b1;
      busy       <= 1'b0;
      wload_req  <= 1'b0;
      conv_start <= 1'b0;
      layer_done <= 1'b0;
    end else begin
      desc_rdy   <= (state_n == IDLE);
      busy       <= (state_n != IDLE);
      wload_req  <= (state_n == WREQ);
      conv_start <= (state_n == START);
      layer_done <= (accept_c && empty_c) || ((state == NEXT) && last_c);
    end
  end

  // Latched configuration and per-group weight address; the address is
  // advanced by one group's bytes (len*4) rather than multiplied out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ch      <= '0;
      out_ch     <= '0;
      map_size   <= '0;
      grp_idx    <= '0;
      wload_addr <= '0;
      wload_len  <= '0;
    end else if (accept_c) begin
      in_ch      <= desc_in_ch;
      out_ch     <= desc_out_ch;
      map_size   <= desc_map_size;
      grp_idx    <= '0;
      wload_addr <= desc_wbase;
      wload_len  <= 16'(desc_in_ch) * WORDS_PER_CH;
    end else if ((state == NEXT) && !last_c) begin
      grp_idx    <= grp_idx + 3'd1;
      wload_addr <= wload_addr + {14'd0, wload_len, 2'b00};
    end
  end

`ifdef CONV_SCHED_PERF_EN
  // Busy-cycle counter: cleared on accept, saturating, holds while idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      perf_cycles <= '0;
    else if (accept_c)
      perf_cycles <= '0;
    else if ((state != IDLE) && (perf_cycles != 32'hFFFF_FFFF))
      perf_cycles <= perf_cycles + 32'd1;
  end
`endif

endmodule

// File: tb/tb_conv_sched.sv
// tb_conv_sched: randomized self-checking bench for conv_sched. The bench acts
// as weight loader and MAC array, and predicts every group address, length,
// index, pulse timing and busy-cycle count from the layer descriptor.
module tb_conv_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        desc_vld;
  logic        desc_rdy;
  logic [7:0]  desc_in_ch;
  logic [7:0]  desc_out_ch;
  logic [15:0] desc_map_size;
  logic [31:0] desc_wbase;
  logic        wload_req;
  logic        wload_ack;
  logic [31:0] wload_addr;
  logic [15:0] wload_len;
  logic        wload_done;
  logic        conv_start;
  logic        conv_done;
  logic [7:0]  in_ch;
  logic [7:0]  out_ch;
  logic [15:0] map_size;
  logic [2:0]  grp_idx;
  logic        layer_done;
  logic        busy;
`ifdef CONV_SCHED_PERF_EN
  logic [31:0] perf_cycles;
`endif

  int checks = 0;
  int errors = 0;
  int starts = 0;
  int reqs   = 0;
  int cyc    = 0;

  always #5 clk = ~clk;

  conv_sched dut (
    .clk(clk), .rst_n(rst_n),
    .desc_vld(desc_vld), .desc_rdy(desc_rdy),
    .desc_in_ch(desc_in_ch), .desc_out_ch(desc_out_ch),
    .desc_map_size(desc_map_size), .desc_wbase(desc_wbase),
    .wload_req(wload_req), .wload_ack(wload_ack),
    .wload_addr(wload_addr), .wload_len(wload_len),
    .wload_done(wload_done),
    .conv_start(conv_start), .conv_done(conv_done),
    .in_ch(in_ch), .out_ch(out_ch), .map_size(map_size),
    .grp_idx(grp_idx), .layer_done(layer_done), .busy(busy)
`ifdef CONV_SCHED_PERF_EN
    , .perf_cycles(perf_cycles)
`endif
  );

  // Event counters for request handshakes and MAC starts.
  always @(posedge clk) begin
    if (wload_req && wload_ack) reqs++;
    if (conv_start) starts++;
  end

  initial begin
    #500us;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
  endtask

  task automatic check_reset_outputs();
    check("rst_rdy", 32'(desc_rdy), 1);
    check("rst_busy", 32'(busy), 0);
    check("rst_req", 32'(wload_req), 0);
    check("rst_start", 32'(conv_start), 0);
    check("rst_ld", 32'(layer_done), 0);
    check("rst_grp", 32'(grp_idx), 0);
    check("rst_addr", wload_addr, 0);
    check("rst_len", 32'(wload_len), 0);
    check("rst_cfg", {in_ch, out_ch, map_size}, 0);
`ifdef CONV_SCHED_PERF_EN
    check("rst_perf", perf_cycles, 0);
`endif
  endtask

  // Negative delay arguments select a random delay.
  task automatic run_layer(input int in_c, input int out_c, input int map, input logic [31:0] wb,
                           input int ack_d, input int ww, input int cw, input int rst_grp,
                           input bit spur);
    int ngrp, len, s0, r0, d;
    logic [31:0] exp_addr;
    bit zero;
    zero = (in_c == 0) || (out_c == 0);
    ngrp = (out_c + 31) / 32;
    len  = in_c * 80;
    s0 = starts;
    r0 = reqs;
    check("rdy_idle", 32'(desc_rdy), 1);
    desc_vld = 1'b1;
    desc_in_ch = 8'(in_c);
    desc_out_ch = 8'(out_c);
    desc_map_size = 16'(map);
    desc_wbase = wb;
    cyc = 0;
    step();
    desc_vld = 1'b0;
    if (zero) begin
      check("ld_empty", 32'(layer_done), 1);
      check("busy_empty", 32'(busy), 0);
      step();
      check("ld_empty_end", 32'(layer_done), 0);
      check("req_empty", 32'(reqs - r0), 0);
      check("start_empty", 32'(starts - s0), 0);
      return;
    end
    for (int g = 0; g < ngrp; g++) begin
      exp_addr = wb + 32'(g) * 32'(len) * 32'd4;
      check("req", 32'(wload_req), 1);
      check("addr", wload_addr, exp_addr);
      check("len", 32'(wload_len), 32'(len));
      check("grp", 32'(grp_idx), 32'(g));
      check("cfg", {in_ch, out_ch, map_size}, {8'(in_c), 8'(out_c), 16'(map)});
      check("busy", 32'(busy), 1);
      check("rdy_busy", 32'(desc_rdy), 0);
      d = (ack_d < 0) ? int'($urandom_range(0, 3)) : ack_d;
      repeat (d) begin
        step();
        check("req_hold", 32'(wload_req), 1);
        check("addr_hold", wload_addr, exp_addr);
        check("len_hold", 32'(wload_len), 32'(len));
      end
      wload_ack = 1'b1;
      step();
      wload_ack = 1'b0;
      check("req_drop", 32'(wload_req), 0);
      d = (ww < 0) ? int'($urandom_range(0, 4)) : ww;
      for (int i = 0; i < d; i++) begin
        conv_done = spur && (i == 0);
        step();
        conv_done = 1'b0;
        check("no_start_wwait", 32'(conv_start), 0);
      end
      wload_done = 1'b1;
      step();
      wload_done = 1'b0;
      check("start", 32'(conv_start), 1);
      step();
      check("start_pulse", 32'(conv_start), 0);
      d = (cw < 0) ? int'($urandom_range(0, 4)) : cw;
      repeat (d) begin
        wload_done = 1'($urandom_range(0, 1));
        desc_vld = 1'($urandom_range(0, 1));
        desc_in_ch = 8'($urandom);
        desc_out_ch = 8'($urandom);
        desc_map_size = 16'($urandom);
        desc_wbase = $urandom;
        step();
        check("no_start_cwait", 32'(conv_start), 0);
        check("rdy_cwait", 32'(desc_rdy), 0);
      end
      wload_done = 1'b0;
      desc_vld = 1'b0;
      if (g == rst_grp) begin
        rst_n = 1'b0;
        #1;
        check_reset_outputs();
        step();
        rst_n = 1'b1;
        step();
        check_reset_outputs();
        return;
      end
      conv_done = 1'b1;
      step();
      conv_done = 1'b0;
      check("next_req", 32'(wload_req), 0);
      check("next_ld", 32'(layer_done), 0);
      step();
      if (g == ngrp - 1) begin
        check("ld", 32'(layer_done), 1);
        check("busy_end", 32'(busy), 0);
        check("rdy_end", 32'(desc_rdy), 1);
        check("req_count", 32'(reqs - r0), 32'(ngrp));
        check("start_count", 32'(starts - s0), 32'(ngrp));
`ifdef CONV_SCHED_PERF_EN
        check("perf", perf_cycles, 32'(cyc - 1));
`endif
        step();
        check("ld_pulse", 32'(layer_done), 0);
        check("cfg_hold", {in_ch, out_ch, map_size}, {8'(in_c), 8'(out_c), 16'(map)});
`ifdef CONV_SCHED_PERF_EN
        check("perf_hold", perf_cycles, 32'(cyc - 2));
`endif
      end
    end
  endtask

  initial begin
    int ic, oc;
    rst_n = 1'b0;
    desc_vld = 1'b0;
    desc_in_ch = '0;
    desc_out_ch = '0;
    desc_map_size = '0;
    desc_wbase = '0;
    wload_ack = 1'b0;
    wload_done = 1'b0;
    conv_done = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs();
    rst_n = 1'b1;
    step();

    run_layer(16, 32, 1024, 32'h0000_1000, -1, -1, -1, -1, 1'b0);
    run_layer(8, 70, 256, 32'h0000_0000, -1, -1, -1, -1, 1'b0);
    run_layer(8, 0, 64, 32'h0000_2000, -1, -1, -1, -1, 1'b0);
    run_layer(0, 40, 64, 32'h0000_2000, -1, -1, -1, -1, 1'b0);
    run_layer(4, 33, 100, 32'h0000_4000, 5, 3, 2, -1, 1'b1);
    run_layer(12, 64, 200, 32'h0000_8000, -1, -1, 3, 1, 1'b0);
    run_layer(12, 64, 200, 32'h0000_8000, -1, -1, -1, -1, 1'b0);
    run_layer(3, 17, 50, 32'h0001_0000, 0, 10, 20, -1, 1'b0);
    run_layer(255, 255, 16'hFFFF, 32'hFFFF_FF00, -1, -1, -1, -1, 1'b1);

    for (int n = 0; n < 25; n++) begin
      ic = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 255));
      oc = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 255));
      run_layer(ic, oc, int'($urandom_range(0, 65535)), $urandom, -1, -1, -1, -1,
                1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/conv_sched.md
CONV_SCHED -- requirements
Module: conv_sched

Interface
REQ-001 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-002 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port desc_vld, input, 1, layer descriptor valid.
REQ-004 SHALL have port desc_rdy, output, 1, scheduler ready to accept a descriptor.
REQ-005 SHALL have port desc_in_ch, input, 8, layer input channel count.
REQ-006 SHALL have port desc_out_ch, input, 8, layer output channel count.
REQ-007 SHALL have port desc_map_size, input, 16, layer feature-map pixel count.
REQ-008 SHALL have port desc_wbase, input, 32, weight base byte address.
REQ-009 SHALL have port wload_req, output, 1, weight-load request, held until wload_ack.
REQ-010 SHALL have port wload_ack, input, 1, weight loader accepted the request.
REQ-011 SHALL have port wload_addr, output, 32, group weight byte address.
REQ-012 SHALL have port wload_len, output, 16, group weight length in 32-bit words.
REQ-013 SHALL have port wload_done, input, 1, one-cycle pulse when the group weights are written into the MAC array.
REQ-014 SHALL have port conv_start, output, 1, one-cycle pulse that starts the MAC array.
REQ-015 SHALL have port conv_done, input, 1, one-cycle pulse when the MAC array finishes a pass.
REQ-016 SHALL have ports in_ch (8), out_ch (8) and map_size (16), outputs, latched layer configuration to the MAC array.
REQ-017 SHALL have port grp_idx, output, 3, current output-channel group index.
REQ-018 SHALL have port layer_done, output, 1, one-cycle pulse at layer completion.
REQ-019 SHALL have port busy, output, 1, high whenever the state is not IDLE.

Function
REQ-020 SHALL implement the states IDLE, WREQ, WWAIT, START, CWAIT and NEXT.
REQ-021 SHALL drive desc_rdy=1 only in IDLE; on desc_vld&&desc_rdy it SHALL latch all descriptor fields, clear grp_idx and move to WREQ.
REQ-022 SHALL compute ngrp = ceil(out_ch/32), which ranges from 1 to 8.
REQ-023 SHALL, on accept with desc_in_ch==0 or desc_out_ch==0, pulse layer_done the next cycle, issue no wload_req or conv_start, and return to IDLE.
REQ-024 SHALL compute wload_len = in_ch*80, unsigned and exact within 16 bits (maximum 20400).
REQ-025 SHALL compute wload_addr = wbase + grp_idx*wload_len*4, with 32-bit wrap-around.
REQ-026 SHALL, in WREQ, hold wload_req=1 with stable wload_addr and wload_len until wload_ack, then go to WWAIT.
REQ-027 SHALL, in WWAIT, wait for wload_done and then go to START; a wload_done seen in any other state SHALL be ignored.
REQ-028 SHALL, in START, assert conv_start for exactly one cycle and go to CWAIT.
REQ-029 SHALL, in CWAIT, wait for conv_done and then go to NEXT.
REQ-030 SHALL, in NEXT, go to WREQ with grp_idx+1 if grp_idx+1 < ngrp; otherwise it SHALL pulse layer_done and go to IDLE.
REQ-031 SHALL take a latency from wload_done to conv_start of exactly 1 cycle, and from conv_done to the next wload_req or layer_done of exactly 2 cycles.
REQ-032 SHALL keep in_ch, out_ch and map_size constant from accept until the next accept.
REQ-033 SHALL ignore desc_vld while busy and SHALL NOT overwrite the latched fields.

Reset
REQ-034 SHALL, on rst_n low (including mid-layer), enter IDLE with desc_rdy=1 and busy=0, and with wload_req, conv_start, layer_done, grp_idx, wload_addr, wload_len, in_ch, out_ch and map_size all 0.

Configuration
REQ-035 SHALL support macro CONV_SCHED_PERF_EN: when defined, it adds output perf_cycles (32 bits), which is cleared on accept, increments each busy cycle (saturating at 0xFFFFFFFF), and holds after layer_done; when undefined, the port and counter SHALL be absent.

Verification
REQ-036 SHALL test in_ch=16, out_ch=32, wbase=0x1000: one wload_req with addr=0x1000 and len=1280, one conv_start, then layer_done 2 cycles after conv_done.
REQ-037 SHALL test in_ch=8, out_ch=70: 3 groups with addr 0x0, 0xA00 and 0x1400, grp_idx 0, 1 and 2, and exactly 3 conv_start pulses.
REQ-038 SHALL test out_ch=0: layer_done 1 cycle after accept, with no wload_req and no conv_start.
REQ-039 SHALL test wload_ack delayed 5 cycles: wload_req stays high and addr and len stay stable; a spurious conv_done during WWAIT is ignored.
REQ-040 SHALL test rst_n asserted during CWAIT of group 1: all outputs reach their reset values and a new descriptor is accepted normally.
REQ-041 SHALL test, with CONV_SCHED_PERF_EN defined, a 1-group layer with 10-cycle weight and 20-cycle conv waits: perf_cycles equals the busy-cycle count, and the value is held after layer_done.
